// File: rtl/ascon_pkg.sv
// ascon_pkg: shared widths, byte counts and serializer state encoding
package ascon_pkg;
  localparam int CIPHER_W = 1472;
  localparam int TAG_W = 128;
  localparam int CIPHER_BYTES_DEF = CIPHER_W / 8;
  localparam int TAG_BYTES_DEF = TAG_W / 8;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, SEND_CIPHER, SEND_TAG, DONE} ser_state_t;
endpackage

// File: rtl/ascon_out_serializer.sv
// ascon_out_serializer: streams a captured ASCON ciphertext then tag, MSB byte first, over a valid/ready byte port
// Ports:
//   clock_i, reset_i (async, active-high)
//   cipher_i/en_cipher_reg_i, tag_i/en_tag_reg_i : capture inputs, honoured only while idle
//   end_ascon_i  : completion level; its rising edge requests a frame
//   byte_o/byte_valid_o/byte_ready_i : output byte handshake
//   busy_o, done_o (one-cycle end-of-frame pulse), overrun_o (sticky capture-while-busy)
module ascon_out_serializer
  import ascon_pkg::*;
#(
  parameter int CIPHER_BYTES = CIPHER_BYTES_DEF,
  parameter int TAG_BYTES = TAG_BYTES_DEF
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [CIPHER_W-1:0] cipher_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic                en_cipher_reg_i,
  input  logic                en_tag_reg_i,
  input  logic                end_ascon_i,
  output logic [7:0]          byte_o,
  output logic                byte_valid_o,
  input  logic                byte_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CIPHER_BYTES - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TAG_BYTES - 1);
  ser_state_t state, state_n;
  logic [CIPHER_W-1:0] cipher_sr;
  logic [TAG_W-1:0] tag_sr;
  logic [CNT_W-1:0] cnt;
  logic cipher_ok, tag_ok, start_pending, end_q;
  logic idle, rise, start, xfer, last;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    idle = state == IDLE;
    rise = end_ascon_i && !end_q;
    byte_valid_o = (state == SEND_CIPHER) || (state == SEND_TAG);
    busy_o = !idle;
    done_o = state == DONE;
    xfer = byte_valid_o && byte_ready_i;
    last = (state == SEND_CIPHER) ? (cnt == C_LAST) : (cnt == T_LAST);
    start = idle && start_pending && cipher_ok && tag_ok;
    byte_o = (state == SEND_CIPHER) ? cipher_sr[CIPHER_W-1 -: 8] :
             (state == SEND_TAG) ? tag_sr[TAG_W-1 -: 8] : 8'h00;
    state_n = state;
    case (state)
      IDLE:        state_n = start ? SEND_CIPHER : IDLE;
      SEND_CIPHER: state_n = (xfer && last) ? SEND_TAG : SEND_CIPHER;
      SEND_TAG:    state_n = (xfer && last) ? DONE : SEND_TAG;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      cipher_sr <= '0;
      tag_sr <= '0;
      cnt <= '0;
      cipher_ok <= 1'b0;
      tag_ok <= 1'b0;
      start_pending <= 1'b0;
      end_q <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      end_q <= end_ascon_i;
      if (busy_o && (en_cipher_reg_i || en_tag_reg_i)) overrun_o <= 1'b1;
      if (idle && en_cipher_reg_i) begin
        cipher_sr <= cipher_i;
        cipher_ok <= 1'b1;
      end
      if (idle && en_tag_reg_i) begin
        tag_sr <= tag_i;
        tag_ok <= 1'b1;
      end
      // a pending request survives until both halves of the frame are present
      if (start) start_pending <= 1'b0;
      else if (idle && rise) start_pending <= 1'b1;
      if (done_o) begin
        cipher_ok <= 1'b0;
        tag_ok <= 1'b0;
      end
      if (xfer) begin
        if (state == SEND_CIPHER) cipher_sr <= {cipher_sr[CIPHER_W-9:0], 8'h00};
        else tag_sr <= {tag_sr[TAG_W-9:0], 8'h00};
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_ascon_out_serializer.sv
// tb_ascon_out_serializer: directed table-driven bench for the ASCON output serializer
module tb_ascon_out_serializer;
  logic clk = 1'b0;
  logic reset_i;
  logic [1471:0] cipher_i;
  logic [127:0] tag_i;
  logic en_cipher_reg_i, en_tag_reg_i, end_ascon_i, byte_ready_i;
  logic [7:0] byte_o;
  logic byte_valid_o, busy_o, done_o, overrun_o;
  int n_checks = 0;
  int n_fail = 0;
  logic [1471:0] cur_cipher;
  logic [127:0] cur_tag;
  logic [7:0] exp_b [200];
  typedef struct {
    bit toggle;
    int hold;
    int exp_done;
  } frame_t;
  frame_t tbl [3];

  ascon_out_serializer dut (
    .clock_i(clk), .reset_i(reset_i), .cipher_i(cipher_i), .tag_i(tag_i),
    .en_cipher_reg_i(en_cipher_reg_i), .en_tag_reg_i(en_tag_reg_i),
    .end_ascon_i(end_ascon_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic build(input logic [7:0] cb, input logic [7:0] tb);
    for (int i = 0; i < 184; i++) begin
      cur_cipher[1471-8*i -: 8] = cb + 8'(i);
      exp_b[i] = cb + 8'(i);
    end
    for (int j = 0; j < 16; j++) begin
      cur_tag[127-8*j -: 8] = tb + 8'(j);
      exp_b[184+j] = tb + 8'(j);
    end
    cipher_i = cur_cipher;
    tag_i = cur_tag;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // caller has just set up the stimulus for the next edge; first valid is expected two edges later
  task automatic run_frame(input bit toggle, input int strobe_at, input int reset_at, input int exp_done);
    int n = 0;
    int idx = 0;
    int first = -1;
    int bad = 0;
    bit seen_done = 0;
    bit strobed = 0;
    while (!seen_done && n < 1000) begin
      cycle();
      n++;
      en_cipher_reg_i = 1'b0;
      en_tag_reg_i = 1'b0;
      cipher_i = cur_cipher;
      byte_ready_i = 1'b1;
      if (byte_valid_o && first < 0) begin
        first = n;
        check("first_valid_edge", n, 2);
      end
      if (done_o) begin
        seen_done = 1;
        check("done_offset", n - first, exp_done);
        check("byte_count", idx, 200);
      end else if (byte_valid_o) begin
        if (idx == reset_at) begin
          reset_i = 1'b1;
          end_ascon_i = 1'b0;
          #1;
          check("rst_byte", byte_o, 0);
          check("rst_valid", byte_valid_o, 0);
          check("rst_busy", busy_o, 0);
          check("rst_done", done_o, 0);
          check("rst_overrun", overrun_o, 0);
          repeat (3) cycle();
          reset_i = 1'b0;
          for (int k = 0; k < 20; k++) begin
            cycle();
            if (byte_valid_o) bad++;
          end
          check("no_bytes_after_reset", bad, 0);
          return;
        end
        check($sformatf("byte[%0d]", idx), byte_o, exp_b[idx]);
        byte_ready_i = toggle ? ((n - first) % 2 == 0) : 1'b1;
        if (byte_ready_i) idx++;
        if (idx == strobe_at && !strobed) begin
          strobed = 1;
          en_cipher_reg_i = 1'b1;
          cipher_i = {184{8'hAA}};
        end
      end
    end
    check("frame_completed", seen_done, 1);
    cycle();
    check("done_one_cycle", done_o, 0);
    check("busy_after_frame", busy_o, 0);
  endtask

  initial begin
    int bad;
    tbl[0] = '{toggle: 1'b0, hold: 0, exp_done: 200};
    tbl[1] = '{toggle: 1'b1, hold: 0, exp_done: 399};
    tbl[2] = '{toggle: 1'b0, hold: 500, exp_done: 200};
    reset_i = 1'b1;
    en_cipher_reg_i = 1'b0;
    en_tag_reg_i = 1'b0;
    end_ascon_i = 1'b0;
    byte_ready_i = 1'b1;
    build(8'h00, 8'hF0);
    #1;
    check("reset_byte", byte_o, 0);
    check("reset_valid", byte_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_overrun", overrun_o, 0);
    repeat (2) cycle();
    reset_i = 1'b0;
    cycle();
    // capture and end_ascon rise in the same idle cycle
    foreach (tbl[t]) begin
      end_ascon_i = 1'b0;
      cycle();
      en_cipher_reg_i = 1'b1;
      en_tag_reg_i = 1'b1;
      end_ascon_i = 1'b1;
      run_frame(tbl[t].toggle, -1, -1, tbl[t].exp_done);
      bad = 0;
      for (int k = 0; k < tbl[t].hold; k++) begin
        cycle();
        if (byte_valid_o || busy_o) bad++;
      end
      check($sformatf("held_end_quiet[%0d]", t), bad, 0);
      check($sformatf("no_overrun[%0d]", t), overrun_o, 0);
    end
    // capture first, then rise; capture strobe mid-frame must be ignored
    end_ascon_i = 1'b0;
    en_cipher_reg_i = 1'b1;
    en_tag_reg_i = 1'b1;
    cycle();
    en_cipher_reg_i = 1'b0;
    en_tag_reg_i = 1'b0;
    cycle();
    end_ascon_i = 1'b1;
    run_frame(1'b0, 50, -1, 200);
    check("overrun_set", overrun_o, 1);
    // reset at byte 100, then a fresh frame with new data
    end_ascon_i = 1'b0;
    cycle();
    en_cipher_reg_i = 1'b1;
    en_tag_reg_i = 1'b1;
    end_ascon_i = 1'b1;
    run_frame(1'b0, -1, 100, 200);
    build(8'h5A, 8'h10);
    en_cipher_reg_i = 1'b1;
    en_tag_reg_i = 1'b1;
    end_ascon_i = 1'b1;
    run_frame(1'b0, -1, -1, 200);
    // rise with only cipher present; tag arrives 10 cycles later
    build(8'h80, 8'h20);
    end_ascon_i = 1'b0;
    en_cipher_reg_i = 1'b1;
    cycle();
    en_cipher_reg_i = 1'b0;
    end_ascon_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (byte_valid_o) bad++;
    end
    check("no_start_without_tag", bad, 0);
    en_tag_reg_i = 1'b1;
    run_frame(1'b0, -1, -1, 200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ascon_out_serializer.md
ASCON_OUT_SERIALIZER -- requirements
Module: ascon_out_serializer

Interface
REQ-001 Parameter CIPHER_BYTES, default 184, number of ciphertext bytes sent (1472 bits).
REQ-002 Parameter TAG_BYTES, default 16, number of tag bytes sent (128 bits).
REQ-003 clock_i  in  1  single clock, all state on rising edge.
REQ-004 reset_i  in  1  reset, asynchronous and active-high.
REQ-005 cipher_i  in  1472  ciphertext from ascon_fsm cipher_o.
REQ-006 tag_i  in  128  tag from ascon_fsm tag_o.
REQ-007 en_cipher_reg_i  in  1  capture strobe for cipher_i.
REQ-008 en_tag_reg_i  in  1  capture strobe for tag_i.
REQ-009 end_ascon_i  in  1  ascon_fsm completion level.
REQ-010 byte_o  out  8  current output byte.
REQ-011 byte_valid_o  out  1  byte_o valid.
REQ-012 byte_ready_i  in  1  downstream accepts byte_o.
REQ-013 busy_o  out  1  high in any state except IDLE.
REQ-014 done_o  out  1  one-cycle pulse, frame complete.
REQ-015 overrun_o  out  1  sticky, capture strobe arrived while busy.

Function
REQ-016 The block SHALL be an FSM with states IDLE, SEND_CIPHER, SEND_TAG, DONE.
REQ-017 In IDLE, en_cipher_reg_i high SHALL load cipher_i into the cipher shift register and set cipher_ok; en_tag_reg_i likewise loads tag_i and sets tag_ok.
REQ-018 A rising edge of end_ascon_i (high now, low previous cycle) SHALL set start_pending; a level held high SHALL NOT re-trigger.
REQ-019 IDLE -> SEND_CIPHER on the clock edge where start_pending, cipher_ok and tag_ok are all registered high; start_pending cleared on that edge.
REQ-020 Timing: end_ascon_i rise sampled at edge N, with both ok flags already set -> byte_valid_o high from edge N+1.
REQ-021 byte_valid_o SHALL be high exactly in SEND_CIPHER and SEND_TAG.
REQ-022 A byte transfers when byte_valid_o and byte_ready_i are high on the same edge; byte_o SHALL stay stable while byte_valid_o high and byte_ready_i low.
REQ-023 Byte order MSB first: byte 0 = cipher_i[1471:1464], byte 183 = cipher_i[7:0], then tag_i[127:120] through tag_i[7:0].
REQ-024 A byte counter SHALL count transfers. After transfer CIPHER_BYTES-1: SEND_CIPHER -> SEND_TAG, counter reset to 0. After transfer TAG_BYTES-1: SEND_TAG -> DONE.
REQ-025 DONE SHALL last one cycle with done_o high, clear cipher_ok and tag_ok, then return to IDLE.
REQ-026 Capture strobes while busy_o high SHALL be ignored, SHALL NOT alter data in flight, and SHALL set overrun_o.
REQ-027 overrun_o clears only on reset.
REQ-028 end_ascon_i rising edges while busy_o high SHALL be ignored and SHALL NOT set start_pending.
REQ-029 A rising edge with an ok flag missing SHALL leave start_pending set until both flags are set.
REQ-030 Strobe and edge in the same IDLE cycle: the capture takes effect on that edge, and the start happens on the following edge.

Reset
REQ-031 On reset_i high, immediately: state IDLE, byte_o 0x00, byte_valid_o 0, busy_o 0, done_o 0, overrun_o 0, ok flags 0, start_pending 0, counter 0, edge-detect register 0.
REQ-032 Reset mid-frame SHALL abort the frame; no byte is emitted after reset release until a new capture and start.

Structure
REQ-033 ascon_pkg SHALL hold CIPHER_W=1472, TAG_W=128, the byte-count constants and the state enum typedef.
REQ-034 No sub-module is required; edge detect, shift registers and counter SHALL be inline.

Verification
REQ-035 cipher bytes 0x00..0xB7, tag bytes 0xF0..0xFF, byte_ready_i=1, end_ascon rise -> 200 bytes on 200 consecutive cycles in order, then a done_o pulse.
REQ-036 Same data, byte_ready_i toggling 1/0 -> byte_o held while not ready, 200 bytes in order, no duplicates.
REQ-037 end_ascon_i held high 500 cycles after the frame -> exactly one frame, busy_o low afterwards.
REQ-038 en_cipher_reg_i pulsed with cipher=all 0xAA at byte 50 -> overrun_o=1, remaining cipher bytes continue 0x32..0xB7.
REQ-039 reset_i asserted at byte 100, then released -> all outputs at reset values; new capture and start gives byte 0 = new cipher_i[1471:1464].
REQ-040 end_ascon rise with only cipher captured, tag strobe 10 cycles later -> first byte valid one edge after the tag capture.
